// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter for the shared 128-bit memory port.
// The ICache and DCache cache controllers share one memory port, with one
// transaction in flight at a time. At the grant edge the winner's request is
// latched, and the completion is routed back to the owner. A sticky watchdog
// flag records any transaction that waited TIMEOUT cycles for memory.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req_i,
  input  logic [ADDR_W-1:0] icache_addr_i,
  output logic              icache_ready_o,
  output logic [LINE_W-1:0] icache_data_o,
  input  logic              dcache_req_i,
  input  logic              dcache_we_i,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic [LINE_W-1:0] dcache_wdata_i,
  output logic              dcache_ready_o,
  output logic [LINE_W-1:0] dcache_data_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  // The counter must be able to hold TIMEOUT. When the watchdog is disabled,
  // a 1-bit counter is kept so that no declaration has zero width.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } state_t;

  state_t            r_state;
  logic              r_rr_last_d;   // 1: DCache won the most recent grant
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;
  logic [1:0]        r_grant;
  logic              r_timeout;

  logic              w_pick_i;
  logic              w_pick_d;
  logic              w_done_i;
  logic              w_done_d;

  // Arbitration choice in IDLE, and completion detection for the current owner.
  always_comb begin
    w_pick_i = icache_req_i && (!dcache_req_i || r_rr_last_d);
    w_pick_d = dcache_req_i && !w_pick_i;
    w_done_i = (r_state == GRANT_I) && mem_ready_i;
    w_done_d = (r_state == GRANT_D) && mem_ready_i;
  end

  // The completion pulse and data are combinational in the mem_ready_i cycle.
  // The data bus is zero for the non-owner and for a DCache write-back.
  always_comb begin
    icache_ready_o = w_done_i;
    dcache_ready_o = w_done_d;
    if (w_done_i) begin
      icache_data_o = mem_rdata_i;
    end else begin
      icache_data_o = {LINE_W{1'b0}};
    end
    if (w_done_d && !r_mem_we) begin
      dcache_data_o = mem_rdata_i;
    end else begin
      dcache_data_o = {LINE_W{1'b0}};
    end
  end

  // Main FSM. It grants the port, latches the transaction, and clears the
  // transaction on completion. It also runs the stall watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_last_d <= 1'b1;
      r_wait_cnt  <= {CNT_W{1'b0}};
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {LINE_W{1'b0}};
      r_grant     <= 2'b00;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wait_cnt <= {CNT_W{1'b0}};
          if (w_pick_i) begin
            r_state     <= GRANT_I;
            r_rr_last_d <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= icache_addr_i;
            r_mem_wdata <= {LINE_W{1'b0}};
            r_grant     <= 2'b01;
          end else if (w_pick_d) begin
            r_state     <= GRANT_D;
            r_rr_last_d <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= dcache_we_i;
            r_mem_addr  <= dcache_addr_i;
            r_mem_wdata <= dcache_we_i ? dcache_wdata_i : {LINE_W{1'b0}};
            r_grant     <= 2'b10;
          end else begin
            r_state <= IDLE;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_ready_i) begin
            r_state     <= IDLE;
            r_wait_cnt  <= {CNT_W{1'b0}};
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {LINE_W{1'b0}};
            r_grant     <= 2'b00;
          end else if ((TIMEOUT > 0) && (r_wait_cnt != TIMEOUT_C)) begin
            // Saturating wait counter. The flag sets on the edge where the
            // counter reaches TIMEOUT, and is never aborted or cleared here.
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            if (r_wait_cnt == (TIMEOUT_C - CNT_W'(1))) begin
              r_timeout <= 1'b1;
            end else begin
              r_timeout <= r_timeout;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_wait_cnt  <= {CNT_W{1'b0}};
          r_mem_req   <= 1'b0;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= {ADDR_W{1'b0}};
          r_mem_wdata <= {LINE_W{1'b0}};
          r_grant     <= 2'b00;
        end
      endcase
    end
  end

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign grant_o     = r_grant;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. Each transaction is pushed to a
// scoreboard queue when its request is driven. It is compared at the grant
// and popped at the completion pulse.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          icache_req_i = 1'b0;
  logic [AW-1:0] icache_addr_i = '0;
  logic          icache_ready_o;
  logic [LW-1:0] icache_data_o;
  logic          dcache_req_i = 1'b0;
  logic          dcache_we_i = 1'b0;
  logic [AW-1:0] dcache_addr_i = '0;
  logic [LW-1:0] dcache_wdata_i = '0;
  logic          dcache_ready_o;
  logic [LW-1:0] dcache_data_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_wdata_o;
  logic          mem_ready_i = 1'b0;
  logic [LW-1:0] mem_rdata_i = '0;
  logic [1:0]    grant_o;
  logic          timeout_o;

  mem_bus_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .icache_req_i(icache_req_i), .icache_addr_i(icache_addr_i),
    .icache_ready_o(icache_ready_o), .icache_data_o(icache_data_o),
    .dcache_req_i(dcache_req_i), .dcache_we_i(dcache_we_i),
    .dcache_addr_i(dcache_addr_i), .dcache_wdata_i(dcache_wdata_i),
    .dcache_ready_o(dcache_ready_o), .dcache_data_o(dcache_data_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    grant;
    logic [AW-1:0] addr;
    logic          we;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [LW-1:0] zero_line = '0;

  // Advance to just after the next rising edge. Inputs are driven here and
  // outputs are sampled one more time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready_i = 1'b1; mem_rdata_i = {16{8'hAA}};
    icache_req_i = 1'b1; icache_addr_i = 32'h0000_0100;
    dcache_req_i = 1'b1; dcache_we_i = 1'b0; dcache_addr_i = 32'h0000_0200;
    step(); step(); #1;
    n_checks++;
    if ({mem_req_o, mem_we_o, grant_o, timeout_o, icache_ready_o, dcache_ready_o, mem_addr_o} !== 39'd0 ||
        mem_wdata_o !== zero_line || icache_data_o !== zero_line || dcache_data_o !== zero_line) begin
      n_errors++; $display("FAIL reset_outputs: got req=%b gnt=%b to=%b irdy=%b drdy=%b addr=%h expected all zero",
                           mem_req_o, grant_o, timeout_o, icache_ready_o, dcache_ready_o, mem_addr_o);
    end
    sb_q.push_back('{2'b01, 32'h0000_0100, 1'b0, '0, {16{8'hAA}}});
    sb_q.push_back('{2'b10, 32'h0000_0200, 1'b0, '0, {16{8'h5C}}});
    // cycle 0: reset released, both requesting
    step(); rst = 1'b0; mem_ready_i = 1'b0; #1;
    n_checks++;
    if (grant_o !== 2'b00) begin n_errors++; $display("FAIL cycle0_grant: got %b expected 00", grant_o); end
    // cycle 1: ICache granted first
    step(); #1; e = sb_q[0];
    n_checks++;
    if (grant_o !== e.grant || mem_addr_o !== e.addr || mem_req_o !== 1'b1 || mem_we_o !== e.we) begin
      n_errors++; $display("FAIL first_grant: got gnt=%b addr=%h req=%b we=%b expected gnt=%b addr=%h req=1 we=%b",
                           grant_o, mem_addr_o, mem_req_o, mem_we_o, e.grant, e.addr, e.we);
    end
    // cycle 2: held
    step(); #1;
    n_checks++;
    if (grant_o !== e.grant || mem_addr_o !== e.addr || mem_req_o !== 1'b1) begin
      n_errors++; $display("FAIL first_hold: got gnt=%b addr=%h req=%b", grant_o, mem_addr_o, mem_req_o);
    end
    // cycle 3: memory completes
    step(); mem_ready_i = 1'b1; mem_rdata_i = e.rdata; #1;
    n_checks++;
    if (icache_ready_o !== 1'b1 || icache_data_o !== e.rdata || dcache_ready_o !== 1'b0 || dcache_data_o !== zero_line) begin
      n_errors++; $display("FAIL first_complete: got irdy=%b idata=%h drdy=%b expected irdy=1 idata=%h drdy=0",
                           icache_ready_o, icache_data_o, dcache_ready_o, e.rdata);
    end
    void'(sb_q.pop_front());
    icache_req_i = 1'b0;
    // cycle 4: bubble
    step(); mem_ready_i = 1'b0; #1;
    n_checks++;
    if (grant_o !== 2'b00 || mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      n_errors++; $display("FAIL first_bubble: got gnt=%b req=%b addr=%h expected 00 0 0", grant_o, mem_req_o, mem_addr_o);
    end
    // cycle 5: DCache granted
    step(); #1; e = sb_q[0];
    n_checks++;
    if (grant_o !== e.grant || mem_addr_o !== e.addr || mem_req_o !== 1'b1) begin
      n_errors++; $display("FAIL second_grant: got gnt=%b addr=%h expected gnt=%b addr=%h", grant_o, mem_addr_o, e.grant, e.addr);
    end
    step(); mem_ready_i = 1'b1; mem_rdata_i = e.rdata; #1;
    n_checks++;
    if (dcache_ready_o !== 1'b1 || dcache_data_o !== e.rdata || icache_ready_o !== 1'b0) begin
      n_errors++; $display("FAIL second_complete: got drdy=%b ddata=%h irdy=%b expected drdy=1 ddata=%h", dcache_ready_o, dcache_data_o, icache_ready_o, e.rdata);
    end
    void'(sb_q.pop_front());
    dcache_req_i = 1'b0;
    step(); mem_ready_i = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] addr_v;
    for (int t = 0; t < 4; t++) begin
      addr_v = ((t % 2) == 0) ? 32'h0000_1000 : 32'h0000_2000;
      addr_v = addr_v + AW'((t / 2) * 16);
      sb_q.push_back('{((t % 2) == 0) ? 2'b01 : 2'b10, addr_v, 1'b0, '0, {$urandom(), $urandom(), $urandom(), $urandom()}});
    end
    icache_req_i = 1'b1; icache_addr_i = 32'h0000_1000;
    dcache_req_i = 1'b1; dcache_we_i = 1'b0; dcache_addr_i = 32'h0000_2000;
    for (int t = 0; t < 4; t++) begin
      step(); #1; e = sb_q[0];
      n_checks++;
      if (grant_o !== e.grant || mem_addr_o !== e.addr || mem_req_o !== 1'b1) begin
        n_errors++; $display("FAIL rr_grant_%0d: got gnt=%b addr=%h req=%b expected gnt=%b addr=%h req=1",
                             t, grant_o, mem_addr_o, mem_req_o, e.grant, e.addr);
      end
      step(); mem_ready_i = 1'b1; mem_rdata_i = e.rdata; #1;
      n_checks++;
      if (e.grant == 2'b01) begin
        if (icache_ready_o !== 1'b1 || icache_data_o !== e.rdata || dcache_ready_o !== 1'b0) begin
          n_errors++; $display("FAIL rr_complete_%0d: got irdy=%b idata=%h drdy=%b expected irdy=1 idata=%h", t, icache_ready_o, icache_data_o, dcache_ready_o, e.rdata);
        end
        icache_addr_i = 32'h0000_1000 + AW'((t / 2 + 1) * 16);
      end else begin
        if (dcache_ready_o !== 1'b1 || dcache_data_o !== e.rdata || icache_ready_o !== 1'b0) begin
          n_errors++; $display("FAIL rr_complete_%0d: got drdy=%b ddata=%h irdy=%b expected drdy=1 ddata=%h", t, dcache_ready_o, dcache_data_o, icache_ready_o, e.rdata);
        end
        dcache_addr_i = 32'h0000_2000 + AW'((t / 2 + 1) * 16);
      end
      void'(sb_q.pop_front());
      step(); mem_ready_i = 1'b0; #1;
      n_checks++;
      if (grant_o !== 2'b00 || mem_req_o !== 1'b0) begin
        n_errors++; $display("FAIL rr_bubble_%0d: got gnt=%b req=%b expected 00 0", t, grant_o, mem_req_o);
      end
      if (t == 3) begin
        icache_req_i = 1'b0; dcache_req_i = 1'b0;
      end
    end
    step(); #1;
    n_checks++;
    if (grant_o !== 2'b00) begin n_errors++; $display("FAIL rr_idle_after: got gnt=%b expected 00", grant_o); end
  endtask

  task automatic test_write_back();
    sb_q.push_back('{2'b10, 32'h0000_03F0, 1'b1, {8{16'h1234}}, {16{8'hFF}}});
    dcache_req_i = 1'b1; dcache_we_i = 1'b1; dcache_addr_i = 32'h0000_03F0; dcache_wdata_i = {8{16'h1234}};
    step(); #1; e = sb_q[0];
    n_checks++;
    if (grant_o !== e.grant || mem_we_o !== 1'b1 || mem_addr_o !== e.addr || mem_wdata_o !== e.wdata) begin
      n_errors++; $display("FAIL wb_grant: got gnt=%b we=%b addr=%h wdata=%h expected gnt=10 we=1 addr=%h wdata=%h",
                           grant_o, mem_we_o, mem_addr_o, mem_wdata_o, e.addr, e.wdata);
    end
    dcache_wdata_i = {4{32'hDEAD_BEEF}}; dcache_addr_i = 32'h0000_0FF0; dcache_we_i = 1'b0;
    step(); #1;
    n_checks++;
    if (mem_wdata_o !== e.wdata || mem_addr_o !== e.addr || mem_we_o !== 1'b1) begin
      n_errors++; $display("FAIL wb_hold: got we=%b addr=%h wdata=%h expected we=1 addr=%h wdata=%h", mem_we_o, mem_addr_o, mem_wdata_o, e.addr, e.wdata);
    end
    step(); mem_ready_i = 1'b1; mem_rdata_i = e.rdata; #1;
    n_checks++;
    if (dcache_ready_o !== 1'b1 || dcache_data_o !== zero_line || icache_ready_o !== 1'b0 || icache_data_o !== zero_line) begin
      n_errors++; $display("FAIL wb_complete: got drdy=%b ddata=%h irdy=%b expected drdy=1 ddata=0 irdy=0", dcache_ready_o, dcache_data_o, icache_ready_o);
    end
    void'(sb_q.pop_front());
    dcache_req_i = 1'b0;
    step(); mem_ready_i = 1'b0; #1;
    n_checks++;
    if (mem_we_o !== 1'b0 || mem_wdata_o !== zero_line || grant_o !== 2'b00) begin
      n_errors++; $display("FAIL wb_clear: got we=%b wdata=%h gnt=%b expected 0 0 00", mem_we_o, mem_wdata_o, grant_o);
    end
  endtask

  task automatic test_drop_and_idle_ready();
    sb_q.push_back('{2'b01, 32'h0000_0500, 1'b0, '0, {4{32'h0BAD_F00D}}});
    icache_req_i = 1'b1; icache_addr_i = 32'h0000_0500;
    step(); #1; e = sb_q[0];
    n_checks++;
    if (grant_o !== e.grant || mem_addr_o !== e.addr) begin
      n_errors++; $display("FAIL drop_grant: got gnt=%b addr=%h expected gnt=01 addr=%h", grant_o, mem_addr_o, e.addr);
    end
    icache_req_i = 1'b0;
    step(); #1;
    n_checks++;
    if (grant_o !== 2'b01 || mem_req_o !== 1'b1) begin
      n_errors++; $display("FAIL drop_hold: got gnt=%b req=%b expected 01 1", grant_o, mem_req_o);
    end
    step(); mem_ready_i = 1'b1; mem_rdata_i = e.rdata; #1;
    n_checks++;
    if (icache_ready_o !== 1'b1 || icache_data_o !== e.rdata) begin
      n_errors++; $display("FAIL drop_complete: got irdy=%b idata=%h expected irdy=1 idata=%h", icache_ready_o, icache_data_o, e.rdata);
    end
    void'(sb_q.pop_front());
    step(); mem_ready_i = 1'b0; #1;
    step(); mem_ready_i = 1'b1; mem_rdata_i = {16{8'h77}}; #1;
    n_checks++;
    if (icache_ready_o !== 1'b0 || dcache_ready_o !== 1'b0 || grant_o !== 2'b00 || icache_data_o !== zero_line) begin
      n_errors++; $display("FAIL idle_ready: got irdy=%b drdy=%b gnt=%b expected 0 0 00", icache_ready_o, dcache_ready_o, grant_o);
    end
    step(); mem_ready_i = 1'b0; #1;
    n_checks++;
    if (grant_o !== 2'b00 || mem_req_o !== 1'b0) begin
      n_errors++; $display("FAIL idle_no_grant: got gnt=%b req=%b expected 00 0", grant_o, mem_req_o);
    end
  endtask

  task automatic test_timeout();
    n_checks++;
    if (timeout_o !== 1'b0) begin n_errors++; $display("FAIL timeout_pre: got %b expected 0", timeout_o); end
    sb_q.push_back('{2'b10, 32'h0000_0600, 1'b0, '0, {4{32'h1357_9BDF}}});
    dcache_req_i = 1'b1; dcache_we_i = 1'b0; dcache_addr_i = 32'h0000_0600;
    for (int i = 1; i <= 8; i++) begin
      step(); #1;
      n_checks++;
      if (timeout_o !== 1'b0 || mem_req_o !== 1'b1 || grant_o !== 2'b10) begin
        n_errors++; $display("FAIL timeout_wait_%0d: got to=%b req=%b gnt=%b expected 0 1 10", i, timeout_o, mem_req_o, grant_o);
      end
      dcache_req_i = 1'b0;
    end
    step(); #1;
    n_checks++;
    if (timeout_o !== 1'b1 || mem_req_o !== 1'b1) begin
      n_errors++; $display("FAIL timeout_set: got to=%b req=%b expected 1 1", timeout_o, mem_req_o);
    end
    step(); step(); mem_ready_i = 1'b1; e = sb_q[0]; mem_rdata_i = e.rdata; #1;
    n_checks++;
    if (dcache_ready_o !== 1'b1 || dcache_data_o !== e.rdata) begin
      n_errors++; $display("FAIL timeout_complete: got drdy=%b ddata=%h expected 1 %h", dcache_ready_o, dcache_data_o, e.rdata);
    end
    void'(sb_q.pop_front());
    step(); mem_ready_i = 1'b0; step(); #1;
    n_checks++;
    if (timeout_o !== 1'b1 || grant_o !== 2'b00) begin
      n_errors++; $display("FAIL timeout_sticky: got to=%b gnt=%b expected 1 00", timeout_o, grant_o);
    end
  endtask

  task automatic test_async_reset();
    icache_req_i = 1'b1; icache_addr_i = 32'h0000_0700;
    step(); #1;
    n_checks++;
    if (grant_o !== 2'b01) begin n_errors++; $display("FAIL ar_pre_grant: got %b expected 01", grant_o); end
    step(); #2;
    rst = 1'b1; mem_ready_i = 1'b1; #1;
    n_checks++;
    if ({mem_req_o, mem_we_o, grant_o, timeout_o, icache_ready_o, dcache_ready_o, mem_addr_o} !== 39'd0 ||
        mem_wdata_o !== zero_line || icache_data_o !== zero_line) begin
      n_errors++; $display("FAIL async_reset: got req=%b gnt=%b to=%b irdy=%b addr=%h expected all zero",
                           mem_req_o, grant_o, timeout_o, icache_ready_o, mem_addr_o);
    end
    dcache_req_i = 1'b1; dcache_we_i = 1'b0; dcache_addr_i = 32'h0000_0800;
    sb_q.push_back('{2'b01, 32'h0000_0700, 1'b0, '0, {4{32'h2468_ACE0}}});
    sb_q.push_back('{2'b10, 32'h0000_0800, 1'b0, '0, {4{32'h1122_3344}}});
    step(); step(); rst = 1'b0; mem_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(); #1; e = sb_q[0];
      n_checks++;
      if (grant_o !== e.grant || mem_addr_o !== e.addr) begin
        n_errors++; $display("FAIL ar_grant_%0d: got gnt=%b addr=%h expected gnt=%b addr=%h", k, grant_o, mem_addr_o, e.grant, e.addr);
      end
      step(); mem_ready_i = 1'b1; mem_rdata_i = e.rdata; #1;
      n_checks++;
      if ((e.grant == 2'b01 && (icache_ready_o !== 1'b1 || icache_data_o !== e.rdata)) ||
          (e.grant == 2'b10 && (dcache_ready_o !== 1'b1 || dcache_data_o !== e.rdata))) begin
        n_errors++; $display("FAIL ar_complete_%0d: got irdy=%b drdy=%b expected owner %b ready", k, icache_ready_o, dcache_ready_o, e.grant);
      end
      void'(sb_q.pop_front());
      if (e.grant == 2'b01) icache_req_i = 1'b0; else dcache_req_i = 1'b0;
      step(); mem_ready_i = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_back();
    test_drop_and_idle_ready();
    test_timeout();
    test_async_reset();
    n_checks++;
    if (sb_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the single 128-bit memory port between ICache line refills and DCache line refills/write-backs.
- Sits between both cache controllers and the memory model/controller.
- Owns the transaction sequencing: grant, address/data latching, completion routing and a stall watchdog.
- Round-robin fairness; one outstanding transaction at a time.

Parameters:
- ADDR_W, 32, address width of all address ports.
- LINE_W, 128, cache line / memory data width.
- TIMEOUT, 256, cycles a granted transaction may wait for mem_ready_i before timeout_o sets (0 disables the watchdog).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- icache_req_i  in  1  ICache refill request; held high until icache_ready_o.
- icache_addr_i  in  ADDR_W  ICache line address, low 4 bits zero.
- icache_ready_o  out  1  one-cycle completion pulse to ICache.
- icache_data_o  out  LINE_W  refill line, valid only while icache_ready_o=1.
- dcache_req_i  in  1  DCache request; held high until dcache_ready_o.
- dcache_we_i  in  1  1 = write-back, 0 = refill.
- dcache_addr_i  in  ADDR_W  DCache line address.
- dcache_wdata_i  in  LINE_W  write-back line.
- dcache_ready_o  out  1  one-cycle completion pulse to DCache.
- dcache_data_o  out  LINE_W  refill line, valid only while dcache_ready_o=1 and the transaction is a read.
- mem_req_o  out  1  memory request, held until mem_ready_i.
- mem_we_o  out  1  write enable to memory.
- mem_addr_o  out  ADDR_W  latched transaction address.
- mem_wdata_o  out  LINE_W  latched write data.
- mem_ready_i  in  1  memory completion pulse.
- mem_rdata_i  in  LINE_W  memory read line, valid with mem_ready_i.
- grant_o  out  2  current owner: 01 = ICache, 10 = DCache, 00 = none.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; rr_last=DCache, so ICache wins the first tie; wait counter 0; timeout_o cleared.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE with no request: remain in IDLE.
- IDLE, single request: move to that requester's GRANT state at the next edge.
- IDLE, both requesting: grant the requester that is not rr_last. rr_last updates to the winner at the grant edge.
- At the grant edge, latch into registers:
  - mem_addr_o from the winner's address.
  - mem_we_o = dcache_we_i for DCache, 0 for ICache.
  - mem_wdata_o = dcache_wdata_i for a DCache write, 0 otherwise.
  - mem_req_o=1 and grant_o set.
- Latency: a request first seen in IDLE at cycle N gives mem_req_o=1 in cycle N+1.
- Requester inputs are ignored after latching; changing them mid-transaction has no effect.
- GRANT_x without mem_ready_i: hold all mem_* outputs stable and increment the wait counter.
- GRANT_x with mem_ready_i=1 (cycle M):
  - The owner's ready_o=1 combinationally in cycle M. data_o = mem_rdata_i for reads; 0 for writes and for the non-owner.
  - At the M edge: mem_req_o, mem_we_o and grant_o return to 0; mem_addr_o and mem_wdata_o clear to 0; wait counter clears; return to IDLE.
  - The earliest new grant edge is M+1, which gives a one-cycle bubble. A requester that drops req after its ready pulse is never re-granted spuriously.
- Owner deasserts req mid-transaction: the transaction still completes and the ready pulse is still issued.
- Non-owner request during GRANT_x: waits. After completion it wins, being non-rr_last.
- mem_ready_i while in IDLE: ignored; no ready pulse.
- Watchdog (TIMEOUT>0):
  - Counter saturates at TIMEOUT.
  - When it reaches TIMEOUT, timeout_o sets and stays set until rst.
  - The transaction is not aborted.
- Counter width: clog2(TIMEOUT+1), minimum 1.

Test Plan:
- Reset with both requests high, then release rst at cycle 0 (ICache addr 0x100, DCache read addr 0x200) -> cycle 1: grant_o=01, mem_addr_o=0x100, mem_req_o=1; mem_ready_i with rdata 0xAA..AA at cycle 3 -> icache_ready_o=1 and icache_data_o=0xAA..AA in cycle 3; DCache granted, mem_addr_o=0x200 in cycle 5.
- Round-robin: both requesters continuously re-request for 4 transactions -> grant order I, D, I, D; each completion is followed by exactly one idle cycle.
- DCache write-back (we=1, addr 0x3F0, wdata 0x1234...) -> mem_we_o=1, mem_wdata_o latched; wdata changed after grant -> mem_wdata_o unchanged; on completion dcache_data_o=0 while dcache_ready_o=1.
- Owner drops req mid-transaction; mem_ready_i pulses while in IDLE -> first: ready still pulses at completion; second: no ready pulse and no state change.
- TIMEOUT=8, mem_ready_i withheld -> timeout_o=1 after the 8th waiting cycle, mem_req_o stays 1; completion later -> timeout_o remains 1 until rst.
- Async rst asserted mid-transaction -> all outputs 0 immediately, without waiting for a clock edge; after release with both requests high -> ICache granted first.
